spart_driver: RTL

Processor-side controller for the `spart` serial port. After reset it programs the `spart` baud divisor from the board switches, then echoes every received byte back out through the transmitter. It drives the `spart` bus interface (`iocs`, `iorw`, `ioaddr`, `databus`) and reprograms the divisor whenever the switch setting changes. It stands in for the processor in the top level.

---
 rtl/spart_driver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spart_driver.sv
// spart_driver: stands in for the processor on the spart bus. Programs the baud
// divisor from the switches, then echoes every received byte back out.
module spart_driver #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TBR_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] echo_cnt,
    output logic       tx_drop,
    output logic       ovr
);

    localparam logic [15:0] DIV_4800  = 16'((CLK_FREQ + 2400) / 4800);
    localparam logic [15:0] DIV_9600  = 16'((CLK_FREQ + 4800) / 9600);
    localparam logic [15:0] DIV_19200 = 16'((CLK_FREQ + 9600) / 19200);
    localparam logic [15:0] DIV_38400 = 16'((CLK_FREQ + 19200) / 38400);

    localparam int               CNT_W    = $clog2(TBR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WAIT_TBR,
        WR
    } state_t;

    state_t           state;
    logic             started;
    logic [1:0]       cfg_meta;
    logic [1:0]       cfg_sync;
    logic [1:0]       cfg_cur;
    logic             rda_pend;
    logic [7:0]       char_reg;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      div_sel;
    logic [7:0]       wdata;

    function automatic logic [15:0] div_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return DIV_4800;
            2'b01:   return DIV_9600;
            2'b10:   return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_meta <= 2'b00;
            cfg_sync <= 2'b00;
        end else begin
            cfg_meta <= br_cfg;
            cfg_sync <= cfg_meta;
        end
    end

    // A new rda always wins over the clear in RD, so a byte arriving during the read is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rda_pend <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (rda) begin
                rda_pend <= 1'b1;
            end else if (state == RD) begin
                rda_pend <= 1'b0;
            end
            if (rda && rda_pend && state != RD) begin
                ovr <= 1'b1;
            end
        end
    end

    // 'started' holds the bus idle during reset while the state already sits at CFG_LO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CFG_LO;
            started  <= 1'b0;
            cfg_cur  <= 2'b00;
            char_reg <= 8'h00;
            wait_cnt <= '0;
            echo_cnt <= 8'h00;
            tx_drop  <= 1'b0;
        end else begin
            tx_drop <= 1'b0;
            if (!started) begin
                started <= 1'b1;
            end else begin
                case (state)
                    CFG_LO: begin
                        cfg_cur <= cfg_sync;
                        state   <= CFG_HI;
                    end
                    CFG_HI: state <= IDLE;
                    IDLE: begin
                        if (rda_pend) begin
                            state <= RD;
                        end else if (cfg_sync != cfg_cur) begin
                            state <= CFG_LO;
                        end
                    end
                    RD: begin
                        char_reg <= databus;
                        wait_cnt <= '0;
                        state    <= WAIT_TBR;
                    end
                    WAIT_TBR: begin
                        if (tbr) begin
                            state <= WR;
                        end else if (wait_cnt == CNT_LAST) begin
                            tx_drop <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    WR: begin
                        echo_cnt <= echo_cnt + 8'd1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // The low byte follows cfg_sync, which is exactly the value CFG_LO latches into cfg_cur.
    assign div_sel = div_of((state == CFG_LO) ? cfg_sync : cfg_cur);

    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        wdata  = 8'h00;
        if (started) begin
            case (state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    wdata  = div_sel[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    wdata  = div_sel[15:8];
                end
                RD: begin
                    iocs = 1'b1;
                end
                WR: begin
                    iocs  = 1'b1;
                    iorw  = 1'b0;
                    wdata = char_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign databus = (iocs && !iorw) ? wdata : 8'hzz;

endmodule
